// File: rtl/demux4x32_buf.sv
// ---------------------------------------------------------------------------
// demux4x32_buf
//   Routes one upstream word stream to four buffered output channels. Each
//   channel owns a small FIFO (DEPTH x WIDTH) with its own read pointer,
//   write pointer and occupancy counter. The upstream side sees
//   back-pressure only from the channel it is currently addressing.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst        : synchronous active-high reset (pointers and counts only)
//   flush      : synchronous clear of all channel FIFOs
//   in_valid   : upstream word present
//   in_ready   : selected channel can accept a word this cycle
//   in_sel     : destination channel 0..3
//   in_data    : upstream word
//   out_valid  : bit k set when channel k has a head word
//   out_ready  : bit k set when channel k's consumer takes the head
//   out_data   : channel k head at [k*WIDTH +: WIDTH]
//   count      : channel k occupancy at [k*CW +: CW], CW = log2(DEPTH)+1
// ---------------------------------------------------------------------------
module demux4x32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        in_sel,
    input  logic [WIDTH-1:0]                  in_data,
    output logic [3:0]                        out_valid,
    input  logic [3:0]                        out_ready,
    output logic [4*WIDTH-1:0]                out_data,
    output logic [4*($clog2(DEPTH)+1)-1:0]    count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = AW + 1;
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    r_rd_ptr [4];
    logic [AW-1:0]    r_wr_ptr [4];
    logic [CW-1:0]    r_cnt    [4];
    logic [WIDTH-1:0] r_mem    [4][DEPTH];

    logic [3:0]       w_full;
    logic [3:0]       w_push;
    logic [3:0]       w_pop;
    logic             w_accept;

    // Back-pressure looks only at the addressed channel's registered count,
    // so a pop on a full channel in the same cycle does not open it up.
    assign in_ready = ~w_full[in_sel];
    assign w_accept = in_valid & in_ready;

    for (genvar k = 0; k < 4; k++) begin : g_ch
        assign w_full[k]                    = (r_cnt[k] == FULL_CNT);
        assign w_push[k]                    = w_accept & (in_sel == 2'(k));
        assign w_pop[k]                     = out_ready[k] & (r_cnt[k] != '0);

        assign out_valid[k]                 = (r_cnt[k] != '0);
        assign out_data[k*WIDTH +: WIDTH]   = r_mem[k][r_rd_ptr[k]];
        assign count[k*CW +: CW]            = r_cnt[k];
    end

    // Pointer and occupancy state. Reset and flush have the same effect on
    // this state; both discard any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_rd_ptr[k] <= '0;
                r_wr_ptr[k] <= '0;
                r_cnt[k]    <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < 4; k++) begin
                r_rd_ptr[k] <= '0;
                r_wr_ptr[k] <= '0;
                r_cnt[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                // DEPTH is a power of two, so pointers wrap by overflow.
                if (w_push[k]) begin
                    r_wr_ptr[k] <= r_wr_ptr[k] + AW'(1);
                end
                if (w_pop[k]) begin
                    r_rd_ptr[k] <= r_rd_ptr[k] + AW'(1);
                end
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_cnt[k] <= r_cnt[k] + CW'(1);
                    2'b01:   r_cnt[k] <= r_cnt[k] - CW'(1);
                    default: r_cnt[k] <= r_cnt[k];
                endcase
            end
        end
    end

    // Storage is not reset; its contents are only observable through
    // out_data while the matching out_valid bit is set.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_push[k] && !rst && !flush) begin
                r_mem[k][r_wr_ptr[k]] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_demux4x32_buf.sv
module tb_demux4x32_buf;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_sel;
    logic [31:0]  in_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [127:0] out_data;
    logic [7:0]   count;

    int errors = 0;
    int checks = 0;

    demux4x32_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] head(input int k);
        return out_data[k*32 +: 32];
    endfunction

    function automatic logic [31:0] cnt(input int k);
        return {30'd0, count[k*2 +: 2]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0;
        in_data = '0; out_ready = 4'b0000;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
        chk("rst_count",     {24'd0, count},     32'h0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'h1);

        // single push to channel 2
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h1111_1111;
        tick();
        in_valid = 1'b0;
        chk("p2_out_valid", {28'd0, out_valid}, 32'h4);
        chk("p2_head",      head(2),            32'h1111_1111);
        chk("p2_count",     {24'd0, count},     32'h10);
        out_ready = 4'b0100;
        tick();
        out_ready = 4'b0000;
        chk("p2_drained",   {28'd0, out_valid}, 32'h0);

        // channel 0 fills, third word held off
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        in_data = 32'hC;
        #1;
        chk("c0_full_ready", {31'd0, in_ready}, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("c0_count",  cnt(0),  32'd2);
        chk("c0_head_a", head(0), 32'hA);
        out_ready = 4'b0001;
        tick();
        chk("c0_head_b",  head(0), 32'hB);
        chk("c0_count_1", cnt(0),  32'd1);
        tick();
        out_ready = 4'b0000;
        chk("c0_empty", {31'd0, out_valid[0]}, 32'h0);

        // channel 1 full does not stall channel 3
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h21;
        tick();
        in_data = 32'h22;
        tick();
        #1;
        chk("c1_full_ready", {31'd0, in_ready}, 32'h0);
        in_sel = 2'd3; in_data = 32'h31;
        #1;
        chk("c3_ready", {31'd0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        chk("c3_count", cnt(3),  32'd1);
        chk("c3_head",  head(3), 32'h31);
        chk("c1_count", cnt(1),  32'd2);
        chk("c1_head",  head(1), 32'h21);

        // simultaneous push and pop on channel 2
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'h4;
        tick();
        chk("c2_one", head(2), 32'h4);
        in_data = 32'h5; out_ready = 4'b0100;
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("c2_pp_count", cnt(2),  32'd1);
        chk("c2_pp_head",  head(2), 32'h5);

        // full channel popping in the same cycle still refuses the push
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'h99; out_ready = 4'b0010;
        #1;
        chk("c1_pop_ready", {31'd0, in_ready}, 32'h0);
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        chk("c1_pop_count", cnt(1),  32'd1);
        chk("c1_pop_head",  head(1), 32'h22);

        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h01;
        tick();
        in_valid = 1'b0;
        chk("all_one", {24'd0, count}, 32'h55);

        // flush with a concurrent push
        flush = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 32'hDEAD;
        #1;
        chk("fl_ready", {31'd0, in_ready}, 32'h1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_count", {24'd0, count},     32'h0);
        chk("fl_valid", {28'd0, out_valid}, 32'h0);
        tick();
        chk("fl_absent", {28'd0, out_valid}, 32'h0);

        // reset mid-traffic overrides push and pop
        in_valid = 1'b1; in_sel = 2'd3; in_data = 32'h71;
        tick();
        in_data = 32'h72;
        tick();
        chk("c3_two", cnt(3), 32'd2);
        rst = 1'b1; in_data = 32'h70; out_ready = 4'b1000;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
        chk("mr_count", {24'd0, count},     32'h0);
        chk("mr_valid", {28'd0, out_valid}, 32'h0);
        chk("mr_ready", {31'd0, in_ready},  32'h1);
        in_valid = 1'b1; in_data = 32'h73;
        tick();
        in_valid = 1'b0;
        chk("mr_head",  head(3), 32'h73);
        chk("mr_cnt",   cnt(3),  32'd1);
        out_ready = 4'b1000;
        tick();
        out_ready = 4'b0000;
        chk("mr_drain", {28'd0, out_valid}, 32'h0);

        // wrap: fill, drain, then streaming push+pop
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'd100;
        tick();
        in_data = 32'd101;
        tick();
        chk("wr_full_ready", {31'd0, in_ready}, 32'h0);
        in_valid = 1'b0; out_ready = 4'b0001;
        #1;
        chk("wr_h0", head(0), 32'd100);
        tick();
        chk("wr_h1", head(0), 32'd101);
        tick();
        chk("wr_empty", {31'd0, out_valid[0]}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 32'd200 + 32'(i);
            if (i > 0) begin
                chk($sformatf("st_head%0d", i), head(0), 32'd200 + 32'(i - 1));
                chk($sformatf("st_cnt%0d", i),  cnt(0),  32'd1);
            end
            tick();
        end
        in_valid = 1'b0;
        chk("st_last", head(0), 32'd205);
        chk("st_lcnt", cnt(0),  32'd1);
        tick();
        out_ready = 4'b0000;
        chk("st_done", cnt(0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
